vx_dram_responder: RTL
======================

// Module: vx_dram_responder
// PURPOSE
//  DRAM-side responder for the cache/DRAM request-response interface (DRAM_LINE_WIDTH lines, tagged reads).
//  Accepts line requests from the memory-unit DRAM arbiter and stores lines in an internal line-wide RAM.
//  Returns read data with the original tag after a fixed latency, in order. Writes produce no response.
//  Serves as the memory endpoint for core/cluster simulation and FPGA bring-up.
// PARAMETERS
//  DATA_WIDTH   512  line width in bits; byteen width = DATA_WIDTH/8
//  ADDR_WIDTH   26   line-address width of req_addr
//  TAG_WIDTH    8    request/response tag width
//  MEM_LINES_W  12   log2 of stored lines; only req_addr[MEM_LINES_W-1:0] indexes storage
//  LATENCY      4    minimum accept-to-rsp_valid cycles for a read (>=2)
//  RSPQ_SIZE    8    max reads in flight plus queued (power of 2, >=2)
// PORTS
//  clk          in   1             clock
//  reset        in   1             asynchronous, active-low reset
//  req_valid    in   1             request valid
//  req_rw       in   1             1 = write, 0 = read
//  req_byteen   in   DATA_WIDTH/8  write byte enables (ignored for reads)
//  req_addr     in   ADDR_WIDTH    line address
//  req_data     in   DATA_WIDTH    write data
//  req_tag      in   TAG_WIDTH     request tag, echoed on read response
//  req_ready    out  1             request accept
//  rsp_valid    out  1             read response valid
//  rsp_data     out  DATA_WIDTH    read line data
//  rsp_tag      out  TAG_WIDTH     tag of the read being answered
//  rsp_ready    in   1             response accept
// BEHAVIOUR
//  - Reset asserted (reset==0): req_ready=0, rsp_valid=0, rsp_data/rsp_tag=0, outstanding=0, pipeline/queue empty.
//    RAM contents are not cleared. Reset mid-operation discards all in-flight and queued reads.
//  - Handshake: req fires when req_valid&&req_ready; rsp fires when rsp_valid&&rsp_ready.
//    req_ready is registered and is independent of req_valid/req_rw.
//    While rsp_valid&&!rsp_ready, rsp_data/rsp_tag are held stable.
//  - outstanding counter (log2(RSPQ_SIZE)+1 bits):
//    - +1 on a read fire, -1 on a rsp fire; unchanged if both occur in the same cycle.
//    - req_ready = (outstanding < RSPQ_SIZE), computed from next-state so it never over-commits.
//    - Writes also require req_ready but do not change outstanding.
//  - Write fire: RAM[addr[MEM_LINES_W-1:0]] bytes with byteen=1 are updated at that edge; other bytes are kept.
//  - Read fire at cycle T:
//    - RAM is sampled at the T edge. A write fired in the same cycle is not visible; a write fired at T-1 or earlier is visible.
//    - {tag,data} enters a (LATENCY-1)-stage non-stalling shift pipeline, then a RSPQ_SIZE-entry FIFO.
//    - rsp_valid is asserted no earlier than T+LATENCY, exactly T+LATENCY when the FIFO is empty.
//  - Responses are strictly in read-acceptance order. Back-to-back reads give one response per cycle if rsp_ready=1.
//  - Credit rule guarantees FIFO space for every pipeline exit; the pipeline never stalls and never drops data.
//  - FIFO full and pipeline exit with simultaneous pop: legal, occupancy unchanged.
//  - Address bits above MEM_LINES_W are ignored, so addresses alias modulo 2^MEM_LINES_W lines.
//  - Elaboration error if LATENCY<2 or RSPQ_SIZE is not a power of 2.
// CONFIGURATION
//  DRAM_RESPONDER_PERF_EN defined: adds 64-bit outputs perf_reads, perf_writes, perf_stalls, perf_lat_sum.
//    - perf_reads / perf_writes count read / write fires.
//    - perf_stalls counts cycles with req_valid&&!req_ready.
//    - perf_lat_sum accumulates outstanding every cycle.
//    - All four counters are reset to 0 by reset.
//  DRAM_RESPONDER_PERF_EN undefined: these ports and counters are absent. Functional behaviour is identical.
// TESTING
//  1. Reset deasserts, no traffic -> req_ready=1 on the first cycle after release; rsp_valid stays 0.
//  2. Write addr=0x10, data=A5.., byteen all-ones, then read addr=0x10, tag=3 at T
//     -> rsp_valid at T+LATENCY, rsp_data=A5.., rsp_tag=3.
//  3. Write byteen=0x...0001 data=0xFF to a line holding 0 -> read returns 0x..00FF; other bytes stay 0.
//  4. rsp_ready=0, stream 10 reads (RSPQ_SIZE=8) -> exactly 8 accepted, req_ready=0.
//     Then raise rsp_ready -> tags return in order 0..7; req_ready reasserts and the remaining 2 complete.
//  5. Read accepted in the same cycle as a write to the same addr -> read returns the old line.
//     A read accepted the next cycle returns the new line.
//  6. Assert reset with 4 reads in flight -> rsp_valid=0 immediately.
//     After release no stale response appears, and RAM data written before reset reads back unchanged.

Source files
------------

// File: rtl/vx_dram_responder.sv
// vx_dram_responder: line-wide DRAM endpoint for the cache/DRAM request-response interface.
// Reads return {tag,data} in acceptance order after a fixed pipeline latency; writes are silent.
// Optional build macro: DRAM_RESPONDER_PERF_EN adds 64-bit performance counter outputs.
// Handshake: a request fires on req_valid_i && req_ready_o and a response fires on
// rsp_valid_o && rsp_ready_i; rsp_data_o/rsp_tag_o stay stable while rsp_valid_o is held.
module vx_dram_responder #(
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 26,
    parameter int TAG_WIDTH   = 8,
    parameter int MEM_LINES_W = 12,
    parameter int LATENCY     = 4,
    parameter int RSPQ_SIZE   = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
`ifdef DRAM_RESPONDER_PERF_EN
    output logic [63:0]             perf_reads_o,
    output logic [63:0]             perf_writes_o,
    output logic [63:0]             perf_stalls_o,
    output logic [63:0]             perf_lat_sum_o,
`endif
    input  logic                    req_valid_i,
    input  logic                    req_rw_i,
    input  logic [DATA_WIDTH/8-1:0] req_byteen_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_data_i,
    input  logic [TAG_WIDTH-1:0]    req_tag_i,
    output logic                    req_ready_o,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic [TAG_WIDTH-1:0]    rsp_tag_o,
    input  logic                    rsp_ready_i
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(RSPQ_SIZE);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = TAG_WIDTH + DATA_WIDTH;
    localparam int STAGES = LATENCY - 1;
    localparam int LINES  = 1 << MEM_LINES_W;

    // Parameter sanity: the pipeline needs at least one stage and the FIFO wraps by power of 2.
    if (LATENCY < 2) begin : g_bad_latency
        $error("vx_dram_responder: LATENCY must be >= 2");
    end
    if (RSPQ_SIZE < 2 || (RSPQ_SIZE & (RSPQ_SIZE - 1)) != 0) begin : g_bad_rspq
        $error("vx_dram_responder: RSPQ_SIZE must be a power of 2 and >= 2");
    end
    if (ADDR_WIDTH < MEM_LINES_W) begin : g_bad_addr
        $error("vx_dram_responder: ADDR_WIDTH must be >= MEM_LINES_W");
    end

    logic                   req_ready_q;
    logic                   rd_fire, wr_fire, rsp_fire;
    logic [MEM_LINES_W-1:0] line_idx;
    logic                   unused_addr_bits;

    logic [DATA_WIDTH-1:0]  mem_q [LINES];

    logic [STAGES-1:0]      pipe_vld_q;
    logic [ENT_W-1:0]       pipe_q [STAGES];

    logic [ENT_W-1:0]       fifo_q [RSPQ_SIZE];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic                   fifo_push;

    logic [CNT_W-1:0]       outst_q, outst_d;

    assign rd_fire   = req_valid_i && req_ready_q && !req_rw_i;
    assign wr_fire   = req_valid_i && req_ready_q && req_rw_i;
    assign rsp_fire  = rsp_valid_o && rsp_ready_i;
    // Upper address bits alias onto the stored lines.
    assign line_idx  = req_addr_i[MEM_LINES_W-1:0];
    assign unused_addr_bits = ^req_addr_i;
    assign fifo_push = pipe_vld_q[STAGES-1];

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign rsp_data_o  = rsp_valid_o ? fifo_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
    assign rsp_tag_o   = rsp_valid_o ? fifo_q[rd_ptr_q][ENT_W-1:DATA_WIDTH] : '0;

    // Line storage with per-byte write enables; contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BYTES; b++) begin
            if (wr_fire && req_byteen_i[b]) begin
                mem_q[line_idx][b*8 +: 8] <= req_data_i[b*8 +: 8];
            end
        end
    end

    // Credit count: reads accepted but not yet answered.
    always_comb begin
        outst_d = outst_q;
        if (rd_fire && !rsp_fire) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!rd_fire && rsp_fire) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    // Ready is registered from the next credit count so a full queue is never over-committed.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            outst_q     <= '0;
            req_ready_q <= 1'b0;
        end else begin
            outst_q     <= outst_d;
            req_ready_q <= (outst_d < CNT_W'(RSPQ_SIZE));
        end
    end

    // Pipeline valid bits: non-stalling shift, cleared by reset to drop in-flight reads.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= rd_fire;
            for (int i = 1; i < STAGES; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    // Pipeline payload: RAM sampled at the accept edge, so a write at that same edge is not seen.
    always_ff @(posedge clk_i) begin
        pipe_q[0] <= {req_tag_i, mem_q[line_idx]};
        for (int i = 1; i < STAGES; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    // FIFO occupancy; push and pop together leave it unchanged, including when full.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push && !rsp_fire) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (!fifo_push && rsp_fire) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end
    end

    // FIFO pointers and count.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rsp_fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage; credits guarantee a free slot (or a simultaneous pop) on every push.
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_q[wr_ptr_q] <= pipe_q[STAGES-1];
        end
    end

`ifdef DRAM_RESPONDER_PERF_EN
    logic [63:0] perf_reads_q, perf_writes_q, perf_stalls_q, perf_lat_sum_q;

    // Performance counters: fires, stalled request cycles, and per-cycle outstanding sum.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_reads_q   <= '0;
            perf_writes_q  <= '0;
            perf_stalls_q  <= '0;
            perf_lat_sum_q <= '0;
        end else begin
            if (rd_fire) perf_reads_q <= perf_reads_q + 64'd1;
            if (wr_fire) perf_writes_q <= perf_writes_q + 64'd1;
            if (req_valid_i && !req_ready_q) perf_stalls_q <= perf_stalls_q + 64'd1;
            perf_lat_sum_q <= perf_lat_sum_q + 64'(outst_q);
        end
    end

    assign perf_reads_o   = perf_reads_q;
    assign perf_writes_o  = perf_writes_q;
    assign perf_stalls_o  = perf_stalls_q;
    assign perf_lat_sum_o = perf_lat_sum_q;
`endif

endmodule
